// File: rtl/cordic_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cordic_pkg : shared constants, quadrant codes and saturating negate        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package cordic_pkg;

   localparam int DATA_W = 16;
   localparam logic [DATA_W-1:0] ONE = 16'h4000;

   // Octant code position inside index_cor at the end of the delay line
   localparam int OCT_MSB = 9;
   localparam int OCT_LSB = 7;
   localparam int OCT_W   = OCT_MSB - OCT_LSB + 1;

   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quad_e;

   // The most negative code has no positive twin, so it clamps to the largest positive code.
   function automatic logic [DATA_W-1:0] sat_neg(input logic [DATA_W-1:0] v);
      if (v == {1'b1, {(DATA_W-1){1'b0}}})
         return {1'b0, {(DATA_W-1){1'b1}}};
      return {DATA_W{1'b0}} - v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_pipe_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cordic_pipe_reg : one valid/ready register slice, full throughput          |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module cordic_pipe_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q;
   logic [WIDTH-1:0] data_q;
   logic             load;

   assign load    = !valid_q || ready_i;
   assign ready_o = load;
   assign valid_o = valid_q;
   assign data_o  = data_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load) begin
         valid_q <= valid_i;
         if (valid_i)
            data_q <= data_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/cordic_octant_fold.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cordic_octant_fold : unfolds first-octant (cos,sin) to the full circle     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module cordic_octant_fold
   import cordic_pkg::*;
#(
   parameter int W     = DATA_W,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_x,
   input  logic [W-1:0]     in_y,
   input  logic [OCT_W-1:0] in_oct,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_cos,
   output logic [W-1:0]     out_sin,
   output logic             sat_sticky,
   output logic [CNT_W-1:0] out_count
);

   localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

   logic [2*W+1:0] w_a_d;
   logic [2*W+1:0] w_a_q;
   logic           w_a_valid;
   logic           w_b_ready;
   logic [2*W:0]   w_b_d;
   logic [2*W:0]   w_b_q;
   quad_e          w_q;
   logic [W-1:0]   w_a;
   logic [W-1:0]   w_b;
   logic [W-1:0]   w_cos;
   logic [W-1:0]   w_sin;
   logic           w_sat;
   logic           w_b_sat;
   logic           sat_q;
   logic           sat_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Stage A: reflect about pi/4 when the half bit is set
   assign w_a_d = in_oct[0] ? {in_oct[2:1], in_y, in_x} : {in_oct[2:1], in_x, in_y};

   cordic_pipe_reg #(.WIDTH(2*W+2)) u_stage_a (
      .clk     (clk),
      .reset   (reset),
      .valid_i (in_valid),
      .ready_o (in_ready),
      .data_i  (w_a_d),
      .valid_o (w_a_valid),
      .ready_i (w_b_ready),
      .data_o  (w_a_q)
   );

   assign w_q = quad_e'(w_a_q[2*W+1:2*W]);
   assign w_a = w_a_q[2*W-1:W];
   assign w_b = w_a_q[W-1:0];

   always_comb begin
      w_cos = w_a;
      w_sin = w_b;
      w_sat = 1'b0;
      case (w_q)
         Q1: begin
            w_cos = sat_neg(w_b);
            w_sin = w_a;
            w_sat = (w_b == MIN_VAL);
         end
         Q2: begin
            w_cos = sat_neg(w_a);
            w_sin = sat_neg(w_b);
            w_sat = (w_a == MIN_VAL) || (w_b == MIN_VAL);
         end
         Q3: begin
            w_cos = w_b;
            w_sin = sat_neg(w_a);
            w_sat = (w_a == MIN_VAL);
         end
         default: ;
      endcase
   end

   assign w_b_d = {w_sat, w_cos, w_sin};

   cordic_pipe_reg #(.WIDTH(2*W+1)) u_stage_b (
      .clk     (clk),
      .reset   (reset),
      .valid_i (w_a_valid),
      .ready_o (w_b_ready),
      .data_i  (w_b_d),
      .valid_o (out_valid),
      .ready_i (out_ready),
      .data_o  (w_b_q)
   );

   assign out_cos = w_b_q[2*W-1:W];
   assign out_sin = w_b_q[W-1:0];
   assign w_b_sat = out_valid && w_b_q[2*W];

   // The flag shows up with the saturated sample itself, then latches
   assign sat_sticky = sat_q || w_b_sat;
   assign out_count  = count_q;

   always_comb begin
      sat_d   = sat_q || w_b_sat;
      count_d = count_q;
      if (out_valid && out_ready)
         count_d = count_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sat_q   <= 1'b0;
         count_q <= '0;
      end else begin
         sat_q   <= sat_d;
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cordic_octant_fold.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_cordic_octant_fold : directed vectors plus reference unfold scoreboard  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_cordic_octant_fold;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_x;
   logic [15:0] in_y;
   logic [2:0]  in_oct;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_cos;
   logic [15:0] out_sin;
   logic        sat_sticky;
   logic [15:0] out_count;

   int          n_pass  = 0;
   int          n_total = 0;
   logic [31:0] exp_q[$];
   logic [15:0] mdl_count = 16'h0;

   always #5 clk = ~clk;

   cordic_octant_fold #(.W(16), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_oct     (in_oct),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_cos    (out_cos),
      .out_sin    (out_sin),
      .sat_sticky (sat_sticky),
      .out_count  (out_count)
   );

   function automatic logic [15:0] neg(input logic [15:0] v);
      return (v == 16'h8000) ? 16'h7FFF : (16'h0000 - v);
   endfunction

   function automatic logic [31:0] unfold(input logic [15:0] x, input logic [15:0] y,
                                          input logic [2:0] oct);
      case (oct)
         3'd0:    return {x, y};
         3'd1:    return {y, x};
         3'd2:    return {neg(y), x};
         3'd3:    return {neg(x), y};
         3'd4:    return {neg(x), neg(y)};
         3'd5:    return {neg(y), neg(x)};
         3'd6:    return {y, neg(x)};
         default: return {x, neg(y)};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic send_chk(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input logic [2:0] oct, input logic [31:0] exp);
      in_x     = x;
      in_y     = y;
      in_oct   = oct;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, {out_cos, out_sin}, exp);
      cyc();
   endtask

   // Scoreboard: handshakes are judged mid-cycle, ahead of the edge that completes them
   always @(negedge clk) begin
      if (!reset) begin
         exp_q.delete();
         mdl_count = 16'h0;
      end else begin
         if (out_valid && out_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
               chk("sb_data", {out_cos, out_sin}, exp_q.pop_front());
            chk("sb_count", 32'(out_count), 32'(mdl_count));
            mdl_count = mdl_count + 16'd1;
         end
         if (in_valid && in_ready)
            exp_q.push_back(unfold(in_x, in_y, in_oct));
      end
   end

   initial begin
      logic [2:0]  soct[4];
      logic [31:0] sexp[4];
      int          idx;
      int          guard;
      int          w;

      soct = '{3'd0, 3'd1, 3'd2, 3'd3};
      sexp = '{32'h3B21_187E, 32'h187E_3B21, 32'hE782_3B21, 32'hC4DF_187E};

      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_x      = 16'h0;
      in_y      = 16'h0;
      in_oct    = 3'd0;
      repeat (2) cyc();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_data", {out_cos, out_sin}, 32'h0);
      chk("rst_sat", 32'(sat_sticky), 32'd0);
      chk("rst_count", 32'(out_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      reset = 1'b1;
      cyc();

      send_chk("oct0", 16'h3B21, 16'h187E, 3'd0, 32'h3B21_187E);
      chk("oct0_count", 32'(out_count), 32'd1);
      send_chk("oct1", 16'h3B21, 16'h187E, 3'd1, 32'h187E_3B21);
      send_chk("oct2", 16'h3B21, 16'h187E, 3'd2, 32'hE782_3B21);
      send_chk("oct5", 16'h3B21, 16'h187E, 3'd5, 32'hE782_C4DF);
      send_chk("oct7", 16'h3B21, 16'h187E, 3'd7, 32'h3B21_E782);
      chk("count5", 32'(out_count), 32'd5);
      chk("sat_clean", 32'(sat_sticky), 32'd0);

      // Saturation: 0x8000 negated in quadrant 2
      in_x = 16'h8000; in_y = 16'h0000; in_oct = 3'd4; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc();
      chk("sat_data", {out_cos, out_sin}, 32'h7FFF_0000);
      chk("sat_set", 32'(sat_sticky), 32'd1);
      cyc();
      send_chk("sat_after", 16'h3B21, 16'h187E, 3'd0, 32'h3B21_187E);
      chk("sat_hold", 32'(sat_sticky), 32'd1);
      chk("count7", 32'(out_count), 32'd7);

      // Stall: four samples offered back to back with the output blocked
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         in_x = 16'h3B21; in_y = 16'h187E; in_oct = soct[idx]; in_valid = 1'b1;
         #1;
         if (in_ready) idx++;
         cyc();
         if (c >= 1) chk("stall_held", {out_cos, out_sin}, sexp[0]);
      end
      chk("stall_accepted", 32'(idx), 32'd2);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_count", 32'(out_count), 32'd7);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("drain_valid", 32'(out_valid), 32'd1);
         chk("drain_data", {out_cos, out_sin}, sexp[k]);
         if (idx < 4) begin
            in_oct   = soct[idx];
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (in_valid && in_ready) idx++;
         cyc();
      end
      in_valid = 1'b0;
      chk("drain_count", 32'(out_count), 32'd11);

      // Reset with two samples in flight and the output stalled
      out_ready = 1'b0;
      in_x = 16'h8000; in_y = 16'h1234; in_oct = 3'd2; in_valid = 1'b1;
      cyc();
      in_x = 16'h0101; in_oct = 3'd6;
      cyc();
      in_valid = 1'b0;
      reset    = 1'b0;
      cyc();
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_sat", 32'(sat_sticky), 32'd0);
      chk("mid_rst_count", 32'(out_count), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      reset     = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("no_stale", 32'(out_valid), 32'd0);
      end

      // Random traffic up to the counter wrap point
      guard = 0;
      while (mdl_count != 16'hFFFF && guard < 90000) begin
         in_valid  = ($urandom_range(63) != 0);
         out_ready = ($urandom_range(63) != 0);
         in_x      = 16'($urandom);
         in_y      = 16'($urandom);
         in_oct    = 3'($urandom);
         if ($urandom_range(255) == 0) in_x = 16'h8000;
         if ($urandom_range(255) == 0) in_y = 16'h8000;
         cyc();
         guard++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("count_ffff", 32'(out_count), 32'h0000_FFFF);
      w = 0;
      while (!out_valid && w < 5) begin
         in_x = 16'h2D41; in_y = 16'h2D41; in_oct = 3'd3; in_valid = 1'b1;
         cyc();
         w++;
      end
      in_valid = 1'b0;
      chk("wrap_out_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      cyc();
      chk("count_wrap", 32'(out_count), 32'd0);
      repeat (4) cyc();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
